fetch_unit: RTL and testbench

- PC/fetch stage directly upstream of inst_mem_64x32 in the MIPS single-cycle core.
- After reset, streams a program image into instruction memory through its write port (LOAD), then fetches sequentially (RUN).
- Computes next-PC from the branch, jump and jr controls supplied by decode/control in the same cycle.
- Stops on BREAK or on a fetch-address fault (HALT).

---
 rtl/mips_pkg.sv | 24 ++
 rtl/next_pc_sel.sv | 39 +++
 rtl/fetch_unit.sv | 133 +++++++++++++
 tb/tb_fetch_unit.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: fetch FSM states and the
// instruction fields needed to recognise BREAK.
package mips_pkg;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    localparam logic [5:0] OPC_SPECIAL = 6'h00;
    localparam logic [5:0] FUNCT_BREAK = 6'h0D;

    localparam int unsigned OPC_MSB   = 31;
    localparam int unsigned OPC_LSB   = 26;
    localparam int unsigned FUNCT_MSB = 5;
    localparam int unsigned FUNCT_LSB = 0;

    function automatic logic is_break(input logic [31:0] word);
        return (word[OPC_MSB:OPC_LSB] == OPC_SPECIAL) &&
               (word[FUNCT_MSB:FUNCT_LSB] == FUNCT_BREAK);
    endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-PC selection (stall > jr > jump > branch > sequential)
// with detection of targets outside the instruction memory or misaligned.
module next_pc_sel #(
    parameter int unsigned ADDR_W = 6
) (
    input  logic [31:0] pc_i,
    input  logic        stall_i,
    input  logic        jr_i,
    input  logic [31:0] jr_target_i,
    input  logic        jump_i,
    input  logic [25:0] jump_target_i,
    input  logic        branch_taken_i,
    input  logic [15:0] branch_imm_i,
    output logic [31:0] pc_plus4_o,
    output logic [31:0] next_pc_o,
    output logic        fault_o
);

    logic [31:0] br_off;

    assign pc_plus4_o = pc_i + 32'd4;
    assign br_off     = {{14{branch_imm_i[15]}}, branch_imm_i, 2'b00};

    always_comb begin
        next_pc_o = pc_plus4_o;
        if (stall_i) begin
            next_pc_o = pc_i;
        end else if (jr_i) begin
            next_pc_o = jr_target_i;
        end else if (jump_i) begin
            next_pc_o = {pc_plus4_o[31:28], jump_target_i, 2'b00};
        end else if (branch_taken_i) begin
            next_pc_o = pc_plus4_o + br_off;
        end
    end

    assign fault_o = (|next_pc_o[31:ADDR_W+2]) | (|next_pc_o[1:0]);

endmodule

// File: rtl/fetch_unit.sv
// PC/fetch stage: streams a program image into instruction memory (LOAD),
// then fetches sequentially with branch/jump/jr redirection until BREAK or fault.
module fetch_unit
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W   = 6,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter bit          LOAD_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [31:0]       ld_data,
    input  logic              ld_last,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wd,
    output logic              im_memwrite,
    output logic              im_memread,
    input  logic [31:0]       im_rd,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [15:0]       branch_imm,
    input  logic              jump,
    input  logic [25:0]       jump_target,
    input  logic              jr,
    input  logic [31:0]       jr_target,
    output logic [31:0]       pc,
    output logic [31:0]       pc_plus4,
    output logic [31:0]       instr,
    output logic              instr_valid,
    output logic              halted,
    output logic              fault
);

    localparam fetch_state_e RESET_ST = LOAD_EN ? ST_LOAD : ST_RUN;

    fetch_state_e      state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              fault_q, fault_d;

    logic [31:0]       pc_cur;
    logic [31:0]       npc;
    logic              npc_fault;

    // Outputs already show reset values during the cycle rst is asserted.
    assign pc_cur = rst ? RESET_PC : pc_q;
    assign pc     = pc_cur;
    assign fault  = rst ? 1'b0 : fault_q;
    assign instr  = im_rd;

    next_pc_sel #(
        .ADDR_W(ADDR_W)
    ) u_next_pc_sel (
        .pc_i          (pc_cur),
        .stall_i       (stall),
        .jr_i          (jr),
        .jr_target_i   (jr_target),
        .jump_i        (jump),
        .jump_target_i (jump_target),
        .branch_taken_i(branch_taken),
        .branch_imm_i  (branch_imm),
        .pc_plus4_o    (pc_plus4),
        .next_pc_o     (npc),
        .fault_o       (npc_fault)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RESET_ST;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        cnt_d       = cnt_q;
        fault_d     = fault_q;
        ld_ready    = 1'b0;
        im_memwrite = 1'b0;
        im_memread  = 1'b0;
        instr_valid = 1'b0;
        halted      = 1'b0;
        im_addr     = pc_cur[ADDR_W+1:2];
        im_wd       = ld_data;

        if (!rst) begin
            unique case (state_q)
                ST_LOAD: begin
                    ld_ready    = 1'b1;
                    im_addr     = cnt_q;
                    im_memwrite = ld_valid;
                    if (ld_valid) begin
                        cnt_d = cnt_q + 1'b1;
                        // Image ends on ld_last or once memory is full.
                        if (ld_last || (cnt_q == '1)) begin
                            state_d = ST_RUN;
                            pc_d    = RESET_PC;
                        end
                    end
                end
                ST_RUN: begin
                    im_memread  = 1'b1;
                    instr_valid = 1'b1;
                    if (!stall && is_break(im_rd)) begin
                        state_d = ST_HALT;
                    end else if (npc_fault) begin
                        state_d = ST_HALT;
                        fault_d = 1'b1;
                    end else begin
                        pc_d = npc;
                    end
                end
                ST_HALT: begin
                    halted = 1'b1;
                end
                default: begin
                    state_d = RESET_ST;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a behavioural model predicts memory writes,
// fetches and halts; a negedge monitor pops and compares against DUT activity.
module tb_fetch_unit;

    localparam int unsigned AW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          ld_valid, ld_ready, ld_last;
    logic [31:0]   ld_data;
    logic [AW-1:0] im_addr;
    logic [31:0]   im_wd, im_rd;
    logic          im_memwrite, im_memread;
    logic          stall, branch_taken, jump, jr;
    logic [15:0]   branch_imm;
    logic [25:0]   jump_target;
    logic [31:0]   jr_target;
    logic [31:0]   pc, pc_plus4, instr;
    logic          instr_valid, halted, fault;

    always #5 clk = ~clk;

    fetch_unit #(
        .ADDR_W  (AW),
        .RESET_PC(32'h0000_0000),
        .LOAD_EN (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_data     (ld_data),
        .ld_last     (ld_last),
        .im_addr     (im_addr),
        .im_wd       (im_wd),
        .im_memwrite (im_memwrite),
        .im_memread  (im_memread),
        .im_rd       (im_rd),
        .stall       (stall),
        .branch_taken(branch_taken),
        .branch_imm  (branch_imm),
        .jump        (jump),
        .jump_target (jump_target),
        .jr          (jr),
        .jr_target   (jr_target),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .instr       (instr),
        .instr_valid (instr_valid),
        .halted      (halted),
        .fault       (fault)
    );

    // Instruction memory stand-in: async read, write on posedge.
    logic [31:0] mem [64] = '{default: 32'h2400_0000};
    assign im_rd = mem[im_addr];
    always @(posedge clk) if (im_memwrite) mem[im_addr] <= im_wd;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
    } pair_t;

    pair_t wr_q[$];
    pair_t fe_q[$];
    pair_t hl_q[$];

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // Reference model state: 0 = loading, 1 = running, 2 = halted.
    logic [31:0] ref_mem [64] = '{default: 32'h2400_0000};
    int unsigned m_mode = 0;
    int unsigned m_cnt  = 0;
    logic [31:0] m_pc   = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Predict this cycle's effect from the current inputs, then advance one clock.
    task automatic tick();
        pair_t       e;
        logic [31:0] w, p4, npc;
        if (rst) begin
            m_mode = 0; m_cnt = 0; m_pc = 32'h0;
        end else if (m_mode == 0) begin
            if (ld_valid) begin
                e.a = m_cnt; e.b = ld_data; wr_q.push_back(e);
                ref_mem[m_cnt] = ld_data;
                m_cnt++;
                if (ld_last || m_cnt == 64) begin
                    m_mode = 1; m_pc = 32'h0;
                end
            end
        end else if (m_mode == 1) begin
            w = ref_mem[m_pc[7:2]];
            e.a = m_pc; e.b = w; fe_q.push_back(e);
            if (!stall && w[31:26] == 6'd0 && w[5:0] == 6'd13) begin
                m_mode = 2; e.a = 0; e.b = m_pc; hl_q.push_back(e);
            end else begin
                p4 = m_pc + 32'd4;
                if (stall)             npc = m_pc;
                else if (jr)           npc = jr_target;
                else if (jump)         npc = (p4 & 32'hF000_0000) + 32'(jump_target) * 32'd4;
                else if (branch_taken) npc = p4 + 32'($signed(branch_imm)) * 32'd4;
                else                   npc = p4;
                if (npc >= 32'd256 || npc % 32'd4 != 0) begin
                    m_mode = 2; e.a = 1; e.b = m_pc; hl_q.push_back(e);
                end else begin
                    m_pc = npc;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ld_valid = 1'b0; ld_last = 1'b0; ld_data = 32'h0;
        stall = 1'b0; branch_taken = 1'b0; jump = 1'b0; jr = 1'b0;
        branch_imm = 16'h0; jump_target = 26'h0; jr_target = 32'h0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic load_word(input logic [31:0] d, input logic last);
        if ($urandom_range(0, 3) == 0) begin
            ld_valid = 1'b0; ld_last = 1'b0;
            tick();
        end
        ld_valid = 1'b1; ld_data = d; ld_last = last;
        tick();
        ld_valid = 1'b0; ld_last = 1'b0;
    endtask

    task automatic run_plain(input int unsigned n);
        idle();
        repeat (n) tick();
    endtask

    // Monitor
    bit          seen_halt = 1'b0;
    logic [31:0] halt_pc   = 32'h0;

    always @(negedge clk) begin
        pair_t e;
        if (rst === 1'b1) begin
            seen_halt = 1'b0;
            chk("rst_pc", pc, 32'h0);
            chk("rst_halted", 32'(halted), 32'd0);
            chk("rst_fault", 32'(fault), 32'd0);
            chk("rst_instr_valid", 32'(instr_valid), 32'd0);
            chk("rst_memwrite", 32'(im_memwrite), 32'd0);
            chk("rst_memread", 32'(im_memread), 32'd0);
            chk("rst_ld_ready", 32'(ld_ready), 32'd0);
        end else if (rst === 1'b0) begin
            if (im_memwrite) begin
                chk("wr_ld_ready", 32'(ld_ready), 32'd1);
                if (wr_q.size() == 0) begin
                    chk("unexpected_write", 32'(im_addr), 32'hFFFF_FFFF);
                end else begin
                    e = wr_q.pop_front();
                    chk("wr_addr", 32'(im_addr), e.a);
                    chk("wr_data", im_wd, e.b);
                end
            end
            if (instr_valid) begin
                if (fe_q.size() == 0) begin
                    chk("unexpected_fetch", pc, 32'hFFFF_FFFF);
                end else begin
                    e = fe_q.pop_front();
                    chk("fetch_pc", pc, e.a);
                    chk("fetch_instr", instr, e.b);
                    chk("fetch_pc_plus4", pc_plus4, e.a + 32'd4);
                    chk("fetch_memread", 32'(im_memread), 32'd1);
                    chk("fetch_ld_ready", 32'(ld_ready), 32'd0);
                end
            end
            if (halted) begin
                if (!seen_halt) begin
                    seen_halt = 1'b1;
                    if (hl_q.size() == 0) begin
                        chk("unexpected_halt", pc, 32'hFFFF_FFFF);
                    end else begin
                        e = hl_q.pop_front();
                        halt_pc = e.b;
                        chk("halt_fault", 32'(fault), e.a);
                    end
                end
                chk("halt_pc", pc, halt_pc);
                chk("halt_instr_valid", 32'(instr_valid), 32'd0);
                chk("halt_memread", 32'(im_memread), 32'd0);
            end
        end
    end

    initial begin
        #500000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned n;
        idle();
        do_reset();

        // Small image ending in BREAK at pc 0x8
        load_word(32'h2008_0005, 1'b0);
        load_word(32'h2009_0003, 1'b0);
        load_word(32'h0000_000D, 1'b1);
        run_plain(5);

        // Sequential, stall, branch, jump, jr-over-jump, out-of-range jr
        do_reset();
        for (int i = 0; i < 6; i++) load_word(32'h0000_0000, (i == 5));
        idle(); tick();
        stall = 1'b1; repeat (3) tick();
        stall = 1'b0; tick();
        branch_taken = 1'b1; branch_imm = 16'hFFFE; tick();
        idle(); jump = 1'b1; jump_target = 26'h4; tick();
        idle(); jr = 1'b1; jump = 1'b1; jump_target = 26'h10; jr_target = 32'h20; tick();
        idle(); jr = 1'b1; jr_target = 32'h100; tick();
        run_plain(3);

        // Misaligned jr
        do_reset();
        load_word(32'h2000_0000, 1'b1);
        idle(); jr = 1'b1; jr_target = 32'h6; tick();
        run_plain(2);

        // Overflow: 70 words offered, never last
        do_reset();
        for (int i = 0; i < 70; i++) begin
            ld_valid = 1'b1; ld_last = 1'b0; ld_data = $urandom | 32'h8000_0000;
            tick();
        end
        idle(); jr = 1'b1; jr_target = 32'hFC; tick();
        run_plain(3);

        // Reset mid-load; old word at address 2 survives
        do_reset();
        for (int i = 0; i < 10; i++) load_word(32'hA000_0000 + 32'(i), 1'b0);
        do_reset();
        load_word(32'hB000_0000, 1'b0);
        load_word(32'hB000_0001, 1'b1);
        run_plain(5);

        // Randomized images and control streams
        for (int r = 0; r < 8; r++) begin
            do_reset();
            n = $urandom_range(1, 16);
            for (int unsigned i = 0; i < n; i++)
                load_word(($urandom_range(0, 15) == 0) ? 32'h0000_000D : $urandom, (i == n - 1));
            for (int c = 0; c < 30; c++) begin
                idle();
                stall        = ($urandom_range(0, 4) == 0);
                jr           = ($urandom_range(0, 9) == 0);
                jr_target    = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 63)) * 32'd4;
                jump         = ($urandom_range(0, 9) == 0);
                jump_target  = 26'($urandom_range(0, 63));
                branch_taken = ($urandom_range(0, 5) == 0);
                branch_imm   = 16'($urandom_range(0, 16)) - 16'd8;
                tick();
            end
        end

        run_plain(2);
        chk("writes_outstanding", wr_q.size(), 32'd0);
        chk("fetches_outstanding", fe_q.size(), 32'd0);
        chk("halts_outstanding", hl_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
